maze_tile_fetch: RTL

Pixel-to-colour fetch pipeline for the maze display. Takes the pixel coordinate stream from the VGA timing stage, looks up the tile code in the maze-layout ROM, then the texel colour in the tile-sprite ROM, and emits one registered colour per pixel with the sync and blank strobes delay-aligned. It sits directly upstream of both `rom` instances: it drives their `en`/`addr` and consumes their one-cycle-latency `dout`.

---
 rtl/maze_tile_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/maze_tile_fetch.sv
// Pixel -> maze tile code -> sprite texel colour, 5-cycle pipeline with aligned strobes.
// Optional player overlay is built only when PLAYER_OVERLAY_EN is defined.
module maze_tile_fetch #(
    parameter int TILE_BITS = 4,
    parameter int MAZE_COLS = 40,
    parameter int MAZE_ROWS = 30,
    parameter int CODE_W    = 4,
    parameter int COLOR_W   = 12,
    parameter int MAZE_AW   = $clog2(MAZE_COLS*MAZE_ROWS),
    parameter int SPR_AW    = CODE_W + 2*TILE_BITS,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = 12'h000,
    parameter logic [COLOR_W-1:0] PLAYER_COLOR = 12'hF00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    input  logic [9:0]                   pix_x,
    input  logic [9:0]                   pix_y,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         blank_in,
    input  logic [$clog2(MAZE_COLS)-1:0] player_col,
    input  logic [$clog2(MAZE_ROWS)-1:0] player_row,
    output logic                         maze_en,
    output logic [MAZE_AW-1:0]           maze_addr,
    input  logic [CODE_W-1:0]            maze_dout,
    output logic                         spr_en,
    output logic [SPR_AW-1:0]            spr_addr,
    input  logic [COLOR_W-1:0]           spr_dout,
    output logic                         rgb_valid,
    output logic [COLOR_W-1:0]           rgb,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         blank_out
);

    logic [4:0] vld_q, vld_d, hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
    logic [3:0] area_q, area_d;
    logic [1:0][TILE_BITS-1:0] xoff_q, xoff_d, yoff_q, yoff_d;
    logic               maze_en_q, maze_en_d, spr_en_q, spr_en_d;
    logic [MAZE_AW-1:0] maze_addr_q, maze_addr_d;
    logic [SPR_AW-1:0]  spr_addr_q, spr_addr_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;

    logic               in_area;
    logic [MAZE_AW-1:0] tile_col, tile_row;

    assign tile_col = MAZE_AW'(pix_x >> TILE_BITS);
    assign tile_row = MAZE_AW'(pix_y >> TILE_BITS);
    assign in_area  = (32'(pix_x) < (MAZE_COLS << TILE_BITS)) &&
                      (32'(pix_y) < (MAZE_ROWS << TILE_BITS));

`ifdef PLAYER_OVERLAY_EN
    logic [3:0] hit_q, hit_d;
    logic       hit;
    assign hit = (32'(pix_x >> TILE_BITS) == 32'(player_col)) &&
                 (32'(pix_y >> TILE_BITS) == 32'(player_row));
    always_comb hit_d = {hit_q[2:0], hit};
`else
    wire unused_player = ^{player_col, player_row};
`endif

    always_comb begin
        // Sideband shifts every cycle regardless of pix_valid so strobes stay aligned.
        vld_d       = {vld_q[3:0], pix_valid};
        hs_d        = {hs_q[3:0], hsync_in};
        vs_d        = {vs_q[3:0], vsync_in};
        bl_d        = {bl_q[3:0], blank_in};
        area_d      = {area_q[2:0], in_area};
        xoff_d      = {xoff_q[0], pix_x[TILE_BITS-1:0]};
        yoff_d      = {yoff_q[0], pix_y[TILE_BITS-1:0]};
        maze_en_d   = pix_valid & in_area;
        maze_addr_d = tile_row * MAZE_AW'(MAZE_COLS) + tile_col;
        spr_en_d    = vld_q[1] & area_q[1];
        spr_addr_d  = SPR_AW'({maze_dout, yoff_q[1], xoff_q[1]});
        rgb_d       = spr_dout;
        if (!area_q[3])
            rgb_d = BORDER_COLOR;
`ifdef PLAYER_OVERLAY_EN
        else if (hit_q[3])
            rgb_d = PLAYER_COLOR;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            hs_q        <= '1;
            vs_q        <= '1;
            bl_q        <= '1;
            area_q      <= '0;
            xoff_q      <= '0;
            yoff_q      <= '0;
            maze_en_q   <= 1'b0;
            maze_addr_q <= '0;
            spr_en_q    <= 1'b0;
            spr_addr_q  <= '0;
            rgb_q       <= '0;
        end else begin
            vld_q       <= vld_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            bl_q        <= bl_d;
            area_q      <= area_d;
            xoff_q      <= xoff_d;
            yoff_q      <= yoff_d;
            maze_en_q   <= maze_en_d;
            maze_addr_q <= maze_addr_d;
            spr_en_q    <= spr_en_d;
            spr_addr_q  <= spr_addr_d;
            rgb_q       <= rgb_d;
        end
    end

`ifdef PLAYER_OVERLAY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit_q <= '0;
        else        hit_q <= hit_d;
    end
`endif

    assign maze_en   = maze_en_q;
    assign maze_addr = maze_addr_q;
    assign spr_en    = spr_en_q;
    assign spr_addr  = spr_addr_q;
    assign rgb       = rgb_q;
    assign rgb_valid = vld_q[4];
    assign hsync_out = hs_q[4];
    assign vsync_out = vs_q[4];
    assign blank_out = bl_q[4];

endmodule
